// File: rtl/fpu_pkg.sv
// Shared constants, encodings and stage bundles for the FPU result encoder.
// Imported by fpu_enc and fpu_enc_round.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int OP_W   = 32;
  localparam int MANT_W = SIG_W + 3;
  localparam int EXPI_W = EXP_W + 2;
  localparam int BIAS   = 127;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int RT_NAN     = 4;
  localparam int RT_POS_INF = 3;
  localparam int RT_NEG_INF = 2;
  localparam int RT_INDET   = 1;
  localparam int RT_FINITE  = 0;

  localparam int FL_NV = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  localparam logic [OP_W-1:0] QNAN       = 32'h7FC0_0000;
  localparam logic [OP_W-1:0] POS_INF    = 32'h7F80_0000;
  localparam logic [OP_W-1:0] NEG_INF    = 32'hFF80_0000;
  localparam logic [OP_W-1:0] MAX_FINITE = 32'h7F7F_FFFF;

  typedef enum logic [2:0] {
    ST_START,
    ST_NORM,
    ST_ROUND,
    ST_READY,
    ST_WAIT
  } enc_state_e;

  typedef struct packed {
    logic [2:0]        rm;
    logic [4:0]        rtype;
    logic [OP_W-1:0]   nan;
    logic              sign;
    logic [EXPI_W-1:0] exp;
    logic [MANT_W-1:0] m;
    logic              sticky;
    logic              tiny;
    logic              zero;
  } enc_norm_t;

endpackage

// File: rtl/fpu_enc_round.sv
// Rounding, overflow saturation and IEEE-754 packing for the result encoder.
// Purely combinational; fed by the registered NORM-stage bundle.
module fpu_enc_round
  import fpu_pkg::*;
(
  input  enc_norm_t       norm_i,
  output logic [OP_W-1:0] result_o,
  output logic [3:0]      flags_o
);

  logic [SIG_W-1:0]  keep;
  logic [SIG_W-1:0]  keep_r;
  logic [SIG_W:0]    sum;
  logic              g;
  logic              s;
  logic              nx;
  logic              inc;
  logic              directed;
  logic              ovf;
  logic signed [EXPI_W:0] exp_f;
  logic [EXP_W-1:0]  exp_field;
  logic [OP_W-1:0]   sat;

  // increment decision, carry and overflow detection
  always_comb begin
    keep     = norm_i.m[MANT_W-1:3];
    g        = norm_i.m[2];
    s        = (|norm_i.m[1:0]) | norm_i.sticky;
    nx       = g | s;
    inc      = 1'b0;
    directed = 1'b0;
    sat      = {norm_i.sign, POS_INF[OP_W-2:0]};
    unique case (norm_i.rm)
      RM_RTZ: begin
        inc      = 1'b0;
        directed = 1'b1;
        sat      = {norm_i.sign, MAX_FINITE[OP_W-2:0]};
      end
      RM_RDN: begin
        inc      = norm_i.sign & nx;
        directed = 1'b1;
        sat      = norm_i.sign ? NEG_INF : MAX_FINITE;
      end
      RM_RUP: begin
        inc      = ~norm_i.sign & nx;
        directed = 1'b1;
        sat      = norm_i.sign ? {1'b1, MAX_FINITE[OP_W-2:0]}
                               : POS_INF;
      end
      RM_RMM: inc = g;
      default: inc = g & (s | keep[0]);
    endcase
    sum    = {1'b0, keep} + {{SIG_W{1'b0}}, inc};
    keep_r = sum[SIG_W] ? {1'b1, {(SIG_W-1){1'b0}}}
                        : sum[SIG_W-1:0];
    exp_f  = $signed({norm_i.exp[EXPI_W-1], norm_i.exp})
           + $signed({{EXPI_W{1'b0}}, sum[SIG_W]});
    // directed modes flag overflow whenever the exact magnitude
    // exceeds MAX_FINITE, even when truncation keeps it finite
    ovf    = ~norm_i.tiny &
             ((exp_f >= (EXPI_W+1)'(EXP_MAX)) |
              (directed & (norm_i.exp == EXPI_W'(EXP_MAX-1)) &
               (&keep) & nx));
    exp_field = norm_i.tiny ? {{(EXP_W-1){1'b0}}, keep_r[SIG_W-1]}
                            : exp_f[EXP_W-1:0];
  end

  // result type priority and final packing
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    if (norm_i.rtype[RT_NAN]) begin
      result_o = norm_i.nan;
    end else if (norm_i.rtype[RT_INDET]) begin
      result_o       = QNAN;
      flags_o[FL_NV] = 1'b1;
    end else if (norm_i.rtype[RT_POS_INF]) begin
      result_o = POS_INF;
    end else if (norm_i.rtype[RT_NEG_INF]) begin
      result_o = NEG_INF;
    end else if (norm_i.zero) begin
      result_o = {norm_i.sign, {(OP_W-1){1'b0}}};
    end else if (ovf) begin
      result_o       = sat;
      flags_o[FL_OF] = 1'b1;
      flags_o[FL_NX] = 1'b1;
    end else begin
      result_o       = {norm_i.sign, exp_field, keep_r[SIG_W-2:0]};
      flags_o[FL_UF] = norm_i.tiny & nx;
      flags_o[FL_NX] = nx;
    end
  end

endmodule

// File: rtl/fpu_enc.sv
// Single-precision FPU result encoder: capture, denormalize, round, pack.
// START/NORM/ROUND/READY/WAIT handshake with a one-cycle ready pulse.
module fpu_enc
  import fpu_pkg::*;
#(
  parameter int EXPONENT_WIDTH    = 8,
  parameter int FRACTION_WIDTH    = 23,
  parameter int SIGNIFICAND_WIDTH = FRACTION_WIDTH + 1,
  parameter int OPERAND_WIDTH     = 32
) (
  input  logic                           fpu_clk,
  input  logic                           fpu_rst,
  input  logic                           fpu_enc_en_i,
  input  logic [2:0]                     fpu_round_mode_i,
  input  logic [4:0]                     fpu_res_type_i,
  input  logic [OPERAND_WIDTH-1:0]       fpu_res_nan_i,
  input  logic                           fpu_res_sign_i,
  input  logic [EXPONENT_WIDTH+1:0]      fpu_res_exp_i,
  input  logic [SIGNIFICAND_WIDTH+2:0]   fpu_res_sfgnd_i,
  output logic [OPERAND_WIDTH-1:0]       fpu_result_o,
  output logic [3:0]                     fpu_flags_o,
  output logic                           fpu_enc_ready_o
);

  enc_state_e      state;
  enc_norm_t       cap_q;
  enc_norm_t       norm_q;
  enc_norm_t       norm_d;
  logic [OP_W-1:0] rnd_result;
  logic [3:0]      rnd_flags;
  logic signed [EXPI_W:0] sh_full;
  logic [4:0]      sh;
  logic [MANT_W-1:0] mask;

  // denormalize: right shift by (1-e) capped at 27, collect sticky
  always_comb begin
    norm_d        = cap_q;
    norm_d.sticky = 1'b0;
    norm_d.tiny   = 1'b0;
    norm_d.zero   = (cap_q.m == '0);
    sh_full = (EXPI_W+1)'(1)
            - $signed({cap_q.exp[EXPI_W-1], cap_q.exp});
    sh      = (sh_full > (EXPI_W+1)'(MANT_W)) ? 5'(MANT_W)
                                              : sh_full[4:0];
    mask    = ~({MANT_W{1'b1}} << sh);
    if (!norm_d.zero && ($signed(cap_q.exp) <= $signed(EXPI_W'(0)))) begin
      norm_d.m      = cap_q.m >> sh;
      norm_d.sticky = |(cap_q.m & mask);
      norm_d.tiny   = 1'b1;
      norm_d.exp    = '0;
    end
  end

  fpu_enc_round u_round (
    .norm_i   (norm_q),
    .result_o (rnd_result),
    .flags_o  (rnd_flags)
  );

  // handshake FSM with input capture, stage register and output registers
  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) begin
      state           <= ST_START;
      cap_q           <= '0;
      norm_q          <= '0;
      fpu_result_o    <= '0;
      fpu_flags_o     <= '0;
      fpu_enc_ready_o <= 1'b0;
    end else begin
      fpu_enc_ready_o <= 1'b0;
      unique case (state)
        ST_START: begin
          if (fpu_enc_en_i) begin
            cap_q.rm     <= fpu_round_mode_i;
            cap_q.rtype  <= fpu_res_type_i;
            cap_q.nan    <= fpu_res_nan_i;
            cap_q.sign   <= fpu_res_sign_i;
            cap_q.exp    <= fpu_res_exp_i;
            cap_q.m      <= fpu_res_sfgnd_i;
            cap_q.sticky <= 1'b0;
            cap_q.tiny   <= 1'b0;
            cap_q.zero   <= 1'b0;
            state        <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (!fpu_enc_en_i) begin
            state <= ST_START;
          end else begin
            norm_q <= norm_d;
            state  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (!fpu_enc_en_i) begin
            state <= ST_START;
          end else begin
            fpu_result_o    <= rnd_result;
            fpu_flags_o     <= rnd_flags;
            fpu_enc_ready_o <= 1'b1;
            state           <= ST_READY;
          end
        end
        ST_READY: begin
          state <= fpu_enc_en_i ? ST_WAIT : ST_START;
        end
        ST_WAIT: begin
          if (!fpu_enc_en_i) begin
            state <= ST_START;
          end
        end
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_enc.sv
// Directed-vector bench for fpu_enc.
// Each task drives one scenario and checks its own results.
module tb_fpu_enc;

  logic        fpu_clk = 1'b0;
  logic        fpu_rst;
  logic        fpu_enc_en_i;
  logic [2:0]  fpu_round_mode_i;
  logic [4:0]  fpu_res_type_i;
  logic [31:0] fpu_res_nan_i;
  logic        fpu_res_sign_i;
  logic [9:0]  fpu_res_exp_i;
  logic [26:0] fpu_res_sfgnd_i;
  logic [31:0] fpu_result_o;
  logic [3:0]  fpu_flags_o;
  logic        fpu_enc_ready_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 fpu_clk = ~fpu_clk;

  fpu_enc dut (
    .fpu_clk          (fpu_clk),
    .fpu_rst          (fpu_rst),
    .fpu_enc_en_i     (fpu_enc_en_i),
    .fpu_round_mode_i (fpu_round_mode_i),
    .fpu_res_type_i   (fpu_res_type_i),
    .fpu_res_nan_i    (fpu_res_nan_i),
    .fpu_res_sign_i   (fpu_res_sign_i),
    .fpu_res_exp_i    (fpu_res_exp_i),
    .fpu_res_sfgnd_i  (fpu_res_sfgnd_i),
    .fpu_result_o     (fpu_result_o),
    .fpu_flags_o      (fpu_flags_o),
    .fpu_enc_ready_o  (fpu_enc_ready_o)
  );

  task automatic drive(input logic [2:0] rm, input logic [4:0] rt,
                       input logic [31:0] nan, input logic sg,
                       input logic [9:0] e, input logic [26:0] m);
    fpu_round_mode_i = rm;
    fpu_res_type_i   = rt;
    fpu_res_nan_i    = nan;
    fpu_res_sign_i   = sg;
    fpu_res_exp_i    = e;
    fpu_res_sfgnd_i  = m;
  endtask

  // one full transaction; lat is the cycle ready was seen, -1 if never
  task automatic run_txn(input logic [2:0] rm, input logic [4:0] rt,
                         input logic [31:0] nan, input logic sg,
                         input logic [9:0] e, input logic [26:0] m,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat);
    @(negedge fpu_clk);
    drive(rm, rt, nan, sg, e, m);
    fpu_enc_en_i = 1'b1;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge fpu_clk);
      if (fpu_enc_ready_o && lat < 0) lat = c;
      if (lat >= 0) break;
    end
    r = fpu_result_o;
    f = fpu_flags_o;
    fpu_enc_en_i = 1'b0;
    @(negedge fpu_clk);
  endtask

  task automatic test_reset();
    fpu_rst = 1'b1;
    fpu_enc_en_i = 1'b0;
    drive(3'd0, 5'd0, 32'd0, 1'b0, 10'd0, 27'd0);
    repeat (2) @(negedge fpu_clk);
    vectors++;
    if (fpu_result_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h want 00000000", fpu_result_o);
    end
    vectors++;
    if (fpu_flags_o !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", fpu_flags_o);
    end
    vectors++;
    if (fpu_enc_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", fpu_enc_ready_o);
    end
    fpu_rst = 1'b0;
  endtask

  task automatic test_exact();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    run_txn(3'b000, 5'b00001, 32'd0, 1'b0, 10'd127, 27'h4000000,
            r, f, lat);
    vectors++;
    if (r !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL exact_result: got %h want 3f800000", r);
    end
    vectors++;
    if (f !== 4'b0000) begin
      miscompares++;
      $display("FAIL exact_flags: got %b want 0000", f);
    end
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL exact_latency: got %0d want 3", lat);
    end
    vectors++;
    if (fpu_enc_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL exact_ready_pulse: got %b want 0 after pulse",
               fpu_enc_ready_o);
    end
  endtask

  // round mode, type, sign, exp, significand, expected result, expected flags
  task automatic test_rounding();
    logic [2:0]  rm_t [10] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b011,
                              3'b010, 3'b000, 3'b000, 3'b011, 3'b111};
    logic [4:0]  rt_t [10] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001,
                              5'b00001, 5'b00001, 5'b00001, 5'b00001,
                              5'b00001, 5'b00000};
    logic        sg_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [9:0]  e_t  [10] = '{10'd127, 10'd127, 10'd254, 10'd254,
                              10'd254, 10'd254, 10'd0, 10'h3E2,
                              10'h3E2, 10'd128};
    logic [26:0] m_t  [10] = '{27'h400000C, 27'h400000C, 27'h7FFFFFF,
                              27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF,
                              27'h4000000, 27'h4000000, 27'h4000000,
                              27'h6000000};
    logic [31:0] xr_t [10] = '{32'h3F800002, 32'h3F800001, 32'h7F800000,
                              32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000,
                              32'h00400000, 32'h00000000, 32'h00000001,
                              32'h40400000};
    logic [3:0]  xf_t [10] = '{4'b0001, 4'b0001, 4'b0101, 4'b0101,
                              4'b0101, 4'b0101, 4'b0000, 4'b0011,
                              4'b0011, 4'b0000};
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_txn(rm_t[i], rt_t[i], 32'd0, sg_t[i], e_t[i], m_t[i],
              r, f, lat);
      vectors++;
      if (r !== xr_t[i] || f !== xf_t[i] || lat != 3) begin
        miscompares++;
        $display("FAIL round_vec%0d: got %h/%b lat %0d want %h/%b lat 3",
                 i, r, f, lat, xr_t[i], xf_t[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [4:0]  rt_t [5] = '{5'b00010, 5'b10000, 5'b01100,
                             5'b00100, 5'b00001};
    logic        sg_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] xr_t [5] = '{32'h7FC00000, 32'h7FC12345, 32'h7F800000,
                             32'hFF800000, 32'h80000000};
    logic [3:0]  xf_t [5] = '{4'b1000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_txn(3'b000, rt_t[i], 32'h7FC12345, sg_t[i], 10'd127,
              (i == 4) ? 27'd0 : 27'h5555555, r, f, lat);
      vectors++;
      if (r !== xr_t[i] || f !== xf_t[i] || lat != 3) begin
        miscompares++;
        $display("FAIL special_vec%0d: got %h/%b lat %0d want %h/%b lat 3",
                 i, r, f, lat, xr_t[i], xf_t[i]);
      end
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    @(negedge fpu_clk);
    drive(3'b000, 5'b00001, 32'd0, 1'b0, 10'd128, 27'h6000000);
    fpu_enc_en_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge fpu_clk);
      if (fpu_enc_ready_o) pulses++;
      if (c == 2) drive(3'b001, 5'b00010, 32'd0, 1'b1, 10'd1, 27'd0);
    end
    fpu_enc_en_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge fpu_clk);
      if (fpu_enc_ready_o) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    vectors++;
    if (fpu_result_o !== 32'h40400000 || fpu_flags_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL hold_result: got %h/%b want 40400000/0000",
               fpu_result_o, fpu_flags_o);
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    int seen = 0;
    run_txn(3'b000, 5'b00001, 32'd0, 1'b0, 10'd127, 27'h4000000,
            r, f, lat);
    @(negedge fpu_clk);
    drive(3'b000, 5'b00010, 32'd0, 1'b0, 10'd0, 27'd0);
    fpu_enc_en_i = 1'b1;
    @(negedge fpu_clk);
    fpu_enc_en_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge fpu_clk);
      if (fpu_enc_ready_o) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_ready: got %0d pulses want 0", seen);
    end
    vectors++;
    if (fpu_result_o !== 32'h3F800000 || fpu_flags_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_hold: got %h/%b want 3f800000/0000",
               fpu_result_o, fpu_flags_o);
    end
  endtask

  task automatic test_reset_in_round();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    run_txn(3'b000, 5'b00010, 32'd0, 1'b0, 10'd0, 27'd0, r, f, lat);
    @(negedge fpu_clk);
    drive(3'b000, 5'b00001, 32'd0, 1'b0, 10'd127, 27'h4000000);
    fpu_enc_en_i = 1'b1;
    repeat (2) @(negedge fpu_clk);
    fpu_rst = 1'b1;
    #1;
    vectors++;
    if (fpu_result_o !== 32'h0 || fpu_flags_o !== 4'h0 ||
        fpu_enc_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_round: got %h/%b/%b want 00000000/0000/0",
               fpu_result_o, fpu_flags_o, fpu_enc_ready_o);
    end
    @(negedge fpu_clk);
    fpu_rst = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge fpu_clk);
      if (fpu_enc_ready_o && lat < 0) lat = c;
      if (lat >= 0) break;
    end
    fpu_enc_en_i = 1'b0;
    vectors++;
    if (lat != 3 || fpu_result_o !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL rst_restart: got lat %0d %h want lat 3 3f800000",
               lat, fpu_result_o);
    end
    @(negedge fpu_clk);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_rounding();
    test_special();
    test_hold();
    test_abort();
    test_reset_in_round();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
